// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises raw LOCK inputs, retries failed locks by pulsing
// the shared PLL reset, and releases per-domain resets in order once all locks are stable.
module pll_lock_supervisor #(
  parameter int unsigned NUM_PLL     = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CYC  = 1024,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned PLL_RST_CYC = 16,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_PLL-1:0] lock_i,
  output logic               pll_rst_o,
  output logic [NUM_PLL-1:0] rst_out_o,
  output logic               all_locked_o,
  output logic [CNT_W-1:0]   loss_cnt_o,
  output logic [CNT_W-1:0]   retry_cnt_o,
  output logic [2:0]         state_o
);

  localparam int unsigned PR_W = $clog2(PLL_RST_CYC) + 1;
  localparam int unsigned ST_W = $clog2(STABLE_CYC) + 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned GP_W = $clog2(GAP_CYC) + 1;
  localparam int unsigned IX_W = $clog2(NUM_PLL) + 1;

  localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CYC - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYC - 1);
  localparam logic [IX_W-1:0] IX_LAST = IX_W'(NUM_PLL - 1);

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } state_t;

  logic [NUM_PLL-1:0] r_sync [SYNC_STAGES];
  logic               w_all_lk;

  state_t             r_state,      w_state_nxt;
  logic [PR_W-1:0]    r_pll_cnt,    w_pll_cnt_nxt;
  logic [ST_W-1:0]    r_stab_cnt,   w_stab_cnt_nxt;
  logic [TO_W-1:0]    r_tmo_cnt,    w_tmo_cnt_nxt;
  logic [GP_W-1:0]    r_gap_cnt,    w_gap_cnt_nxt;
  logic [IX_W-1:0]    r_idx,        w_idx_nxt;
  logic [IX_W-1:0]    w_idx_inc;
  logic               r_pll_rst,    w_pll_rst_nxt;
  logic [NUM_PLL-1:0] r_rst_out,    w_rst_out_nxt;
  logic               r_all_locked, w_all_locked_nxt;
  logic [CNT_W-1:0]   r_loss_cnt,   w_loss_cnt_nxt;
  logic [CNT_W-1:0]   r_retry_cnt,  w_retry_cnt_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= lock_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_all_lk  = &r_sync[SYNC_STAGES-1];
  assign w_idx_inc = r_idx + 1'b1;

  // Timers are held at zero outside their own state so every entry starts fresh.
  always_comb begin
    w_state_nxt     = r_state;
    w_pll_cnt_nxt   = '0;
    w_stab_cnt_nxt  = '0;
    w_tmo_cnt_nxt   = '0;
    w_gap_cnt_nxt   = '0;
    w_idx_nxt       = '0;
    w_rst_out_nxt   = r_rst_out;
    w_loss_cnt_nxt  = r_loss_cnt;
    w_retry_cnt_nxt = r_retry_cnt;

    case (r_state)
      RST_PLL: begin
        w_rst_out_nxt = '1;
        if (r_pll_cnt == PR_LAST) w_state_nxt = WAIT_LOCK;
        else                      w_pll_cnt_nxt = r_pll_cnt + 1'b1;
      end

      WAIT_LOCK: begin
        w_rst_out_nxt = '1;
        if (w_all_lk && (r_stab_cnt == ST_LAST)) begin
          w_state_nxt      = RELEASE;
          w_rst_out_nxt[0] = 1'b0;
        end else if (r_tmo_cnt == TO_LAST) begin
          w_state_nxt = RST_PLL;
          if (r_retry_cnt != '1) w_retry_cnt_nxt = r_retry_cnt + 1'b1;
        end else begin
          w_tmo_cnt_nxt  = r_tmo_cnt + 1'b1;
          w_stab_cnt_nxt = w_all_lk ? r_stab_cnt + 1'b1 : '0;
        end
      end

      RELEASE, RUN: begin
        if (!w_all_lk) begin
          w_state_nxt   = WAIT_LOCK;
          w_rst_out_nxt = '1;
          if (r_loss_cnt != '1) w_loss_cnt_nxt = r_loss_cnt + 1'b1;
        end else if (r_state == RUN) begin
          w_rst_out_nxt = '0;
        end else if (r_gap_cnt == GP_LAST) begin
          if (r_idx == IX_LAST) begin
            w_state_nxt = RUN;
          end else begin
            w_idx_nxt = w_idx_inc;
            for (int unsigned i = 1; i < NUM_PLL; i++) begin
              if (IX_W'(i) == w_idx_inc) w_rst_out_nxt[i] = 1'b0;
            end
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
          w_idx_nxt     = r_idx;
        end
      end

      default: begin
        w_state_nxt   = RST_PLL;
        w_rst_out_nxt = '1;
      end
    endcase

    w_pll_rst_nxt    = (w_state_nxt == RST_PLL);
    w_all_locked_nxt = (w_state_nxt == RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= RST_PLL;
      r_pll_cnt    <= '0;
      r_stab_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_idx        <= '0;
      r_pll_rst    <= 1'b1;
      r_rst_out    <= '1;
      r_all_locked <= 1'b0;
      r_loss_cnt   <= '0;
      r_retry_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pll_cnt    <= w_pll_cnt_nxt;
      r_stab_cnt   <= w_stab_cnt_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_pll_rst    <= w_pll_rst_nxt;
      r_rst_out    <= w_rst_out_nxt;
      r_all_locked <= w_all_locked_nxt;
      r_loss_cnt   <= w_loss_cnt_nxt;
      r_retry_cnt  <= w_retry_cnt_nxt;
    end
  end

  assign pll_rst_o    = r_pll_rst;
  assign rst_out_o    = r_rst_out;
  assign all_locked_o = r_all_locked;
  assign loss_cnt_o   = r_loss_cnt;
  assign retry_cnt_o  = r_retry_cnt;
  assign state_o      = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed sequences on a default instance, a table-driven
// instance with tiny parameters, and a randomized instance checked against a timeline model.
module tb_pll_lock_supervisor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Instance A: default parameters
  logic       rst_a = 1'b1;
  logic [1:0] lock_a = '0;
  logic       pll_a, al_a;
  logic [1:0] rsto_a;
  logic [7:0] loss_a, retry_a;
  logic [2:0] st_a;

  pll_lock_supervisor u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .lock_i(lock_a), .pll_rst_o(pll_a), .rst_out_o(rsto_a),
    .all_locked_o(al_a), .loss_cnt_o(loss_a), .retry_cnt_o(retry_a), .state_o(st_a)
  );

  // Instance B: scaled timing, randomized and checked against the model
  localparam int BN = 3, BS = 3, BST = 40, BTO = 100, BPR = 16, BG = 4;
  logic          rst_b = 1'b1;
  logic [BN-1:0] lock_b = '0;
  logic          pll_b, al_b;
  logic [BN-1:0] rsto_b;
  logic [7:0]    loss_b, retry_b;
  logic [2:0]    st_b;

  pll_lock_supervisor #(
    .NUM_PLL(BN), .SYNC_STAGES(BS), .STABLE_CYC(BST), .TIMEOUT_CYC(BTO),
    .PLL_RST_CYC(BPR), .GAP_CYC(BG), .CNT_W(8)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .lock_i(lock_b), .pll_rst_o(pll_b), .rst_out_o(rsto_b),
    .all_locked_o(al_b), .loss_cnt_o(loss_b), .retry_cnt_o(retry_b), .state_o(st_b)
  );

  // Instance C: minimal timing, 2-bit counters, table-driven
  logic       rst_c = 1'b1;
  logic [0:0] lock_c = '0;
  logic       pll_c, al_c;
  logic [0:0] rsto_c;
  logic [1:0] loss_c, retry_c;
  logic [2:0] st_c;

  pll_lock_supervisor #(
    .NUM_PLL(1), .SYNC_STAGES(2), .STABLE_CYC(2), .TIMEOUT_CYC(6),
    .PLL_RST_CYC(2), .GAP_CYC(1), .CNT_W(2)
  ) u_dut_c (
    .clk_i(clk), .rst_i(rst_c), .lock_i(lock_c), .pll_rst_o(pll_c), .rst_out_o(rsto_c),
    .all_locked_o(al_c), .loss_cnt_o(loss_c), .retry_cnt_o(retry_c), .state_o(st_c)
  );

  // ---------------- instance A: directed sequences ----------------
  task automatic a_reset_chk(input string tag);
    chk({tag, "_pll_rst"}, int'(pll_a), 1);
    chk({tag, "_rst_out"}, int'(rsto_a), 3);
    chk({tag, "_all_locked"}, int'(al_a), 0);
    chk({tag, "_loss"}, int'(loss_a), 0);
    chk({tag, "_retry"}, int'(retry_a), 0);
    chk({tag, "_state"}, int'(st_a), 0);
  endtask

  task automatic run_a();
    bit pll_seen = 1'b0;
    @(negedge clk);
    a_reset_chk("a_reset");
    rst_a = 1'b0;
    repeat (15) @(negedge clk);
    chk("a_pll_rst_edge15", int'(pll_a), 1);
    chk("a_state_edge15", int'(st_a), 0);
    @(negedge clk);
    chk("a_pll_rst_edge16", int'(pll_a), 0);
    chk("a_state_edge16", int'(st_a), 1);
    repeat (14) @(negedge clk);
    lock_a = 2'b11;
    repeat (1025) @(negedge clk);
    chk("a_rst_out_edge1055", int'(rsto_a), 3);
    chk("a_state_edge1055", int'(st_a), 1);
    @(negedge clk);
    chk("a_rst_out_edge1056", int'(rsto_a), 2);
    chk("a_state_edge1056", int'(st_a), 2);
    repeat (7) @(negedge clk);
    chk("a_rst_out_edge1063", int'(rsto_a), 2);
    @(negedge clk);
    chk("a_rst_out_edge1064", int'(rsto_a), 0);
    chk("a_all_locked_edge1064", int'(al_a), 0);
    repeat (7) @(negedge clk);
    chk("a_all_locked_edge1071", int'(al_a), 0);
    @(negedge clk);
    chk("a_all_locked_edge1072", int'(al_a), 1);
    chk("a_state_run", int'(st_a), 3);
    repeat (10) @(negedge clk);
    lock_a = 2'b01;
    @(negedge clk);
    lock_a = 2'b11;
    @(negedge clk);
    chk("a_loss_not_yet_rst_out", int'(rsto_a), 0);
    chk("a_loss_not_yet_state", int'(st_a), 3);
    @(negedge clk);
    chk("a_loss_rst_out", int'(rsto_a), 3);
    chk("a_loss_cnt", int'(loss_a), 1);
    chk("a_loss_state", int'(st_a), 1);
    chk("a_loss_all_locked", int'(al_a), 0);
    for (int i = 0; i < 1023; i++) begin
      @(negedge clk);
      if (pll_a) pll_seen = 1'b1;
    end
    chk("a_relock_pll_rst_quiet", int'(pll_seen), 0);
    chk("a_relock_state_before", int'(st_a), 1);
    @(negedge clk);
    chk("a_relock_state", int'(st_a), 2);
    chk("a_relock_rst_out", int'(rsto_a), 2);
    @(negedge clk);
    #2 rst_a = 1'b1;
    #1 a_reset_chk("a_async_reset");
    @(negedge clk);
    rst_a = 1'b0;
    repeat (15) @(negedge clk);
    chk("a_restart_pll_rst_hold", int'(pll_a), 1);
    @(negedge clk);
    chk("a_restart_pll_rst_end", int'(pll_a), 0);
    chk("a_restart_state", int'(st_a), 1);
  endtask

  // ---------------- instance C: table-driven ----------------
  typedef struct {
    int lk; int n; int pll; int rst; int al; int loss; int retry; int st;
  } vec_t;

  task automatic run_c();
    vec_t tbl[$];
    int   ls, pls;
    tbl.push_back(vec_t'{1, 1, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 0, 0, 1});
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 0, 0, 1});
    tbl.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 2});
    tbl.push_back(vec_t'{1, 1, 0, 0, 1, 0, 0, 3});
    for (int i = 1; i <= 5; i++) begin
      ls  = (i > 3) ? 3 : i;
      pls = (i - 1 > 3) ? 3 : i - 1;
      tbl.push_back(vec_t'{0, 1, 0, 0, 1, pls, 0, 3});
      tbl.push_back(vec_t'{1, 2, 0, 1, 0, ls, 0, 1});
      tbl.push_back(vec_t'{1, 2, 0, 0, 0, ls, 0, 2});
      tbl.push_back(vec_t'{1, 1, 0, 0, 1, ls, 0, 3});
    end
    tbl.push_back(vec_t'{0, 3, 0, 1, 0, 3, 0, 1});
    tbl.push_back(vec_t'{0, 5, 0, 1, 0, 3, 0, 1});
    tbl.push_back(vec_t'{0, 1, 1, 1, 0, 3, 1, 0});
    tbl.push_back(vec_t'{0, 2, 0, 1, 0, 3, 1, 1});

    @(negedge clk);
    chk("c_reset_pll_rst", int'(pll_c), 1);
    chk("c_reset_rst_out", int'(rsto_c), 1);
    chk("c_reset_state", int'(st_c), 0);
    rst_c = 1'b0;
    foreach (tbl[r]) begin
      lock_c = tbl[r].lk[0:0];
      repeat (tbl[r].n) @(negedge clk);
      chk($sformatf("c_row%0d_pll_rst", r), int'(pll_c), tbl[r].pll);
      chk($sformatf("c_row%0d_rst_out", r), int'(rsto_c), tbl[r].rst);
      chk($sformatf("c_row%0d_all_locked", r), int'(al_c), tbl[r].al);
      chk($sformatf("c_row%0d_loss", r), int'(loss_c), tbl[r].loss);
      chk($sformatf("c_row%0d_retry", r), int'(retry_c), tbl[r].retry);
      chk($sformatf("c_row%0d_state", r), int'(st_c), tbl[r].st);
    end
  endtask

  // ---------------- instance B: timeline model ----------------
  // phase: 0 PLL reset, 1 qualifying, 2 releasing, 3 running; m_t = cycles spent in phase
  int            m_phase, m_t, m_run, m_loss, m_retry;
  logic [BN-1:0] m_sync [BS];

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_run = 0; m_loss = 0; m_retry = 0;
    for (int i = 0; i < BS; i++) m_sync[i] = '0;
  endtask

  task automatic model_step(input logic [BN-1:0] lk);
    bit all_lk = &m_sync[BS-1];
    if (m_phase == 0) begin
      if (m_t == BPR - 1) begin m_phase = 1; m_t = 0; m_run = 0; end
      else m_t++;
    end else if (m_phase == 1) begin
      if (all_lk && m_run == BST - 1) begin
        m_phase = 2; m_t = 0;
      end else if (m_t == BTO - 1) begin
        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
        m_phase = 0; m_t = 0;
      end else begin
        m_t++;
        m_run = all_lk ? m_run + 1 : 0;
      end
    end else if (!all_lk) begin
      m_loss = (m_loss < 255) ? m_loss + 1 : 255;
      m_phase = 1; m_t = 0; m_run = 0;
    end else if (m_phase == 2) begin
      if (m_t == BN * BG - 1) begin m_phase = 3; m_t = 0; end
      else m_t++;
    end
    for (int i = BS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = lk;
  endtask

  function automatic int model_rst_out();
    int all1 = (1 << BN) - 1;
    int cl;
    if (m_phase == 3) return 0;
    if (m_phase != 2) return all1;
    cl = m_t / BG + 1;
    if (cl > BN) cl = BN;
    return all1 & ~((1 << cl) - 1);
  endfunction

  task automatic b_cmp();
    chk("b_pll_rst", int'(pll_b), (m_phase == 0) ? 1 : 0);
    chk("b_rst_out", int'(rsto_b), model_rst_out());
    chk("b_all_locked", int'(al_b), (m_phase == 3) ? 1 : 0);
    chk("b_state", int'(st_b), m_phase);
    chk("b_loss", int'(loss_b), m_loss);
    chk("b_retry", int'(retry_b), m_retry);
  endtask

  task automatic b_cycle(input logic [BN-1:0] v);
    b_cmp();
    lock_b = v;
    model_step(v);
    @(negedge clk);
  endtask

  task automatic run_b();
    logic [BN-1:0] v;
    int            len, sel, retry0, rel_seen, prev;
    int            rises[$];
    int            falls[$];
    @(negedge clk);
    model_reset();
    rst_b = 1'b0;
    for (int s = 0; s < 60; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        v = '1; len = $urandom_range(20, 120);
      end else if (sel < 7) begin
        v = BN'($urandom_range(0, (1 << BN) - 1)); len = $urandom_range(1, 6);
      end else if (sel < 9) begin
        v = '1; v[$urandom_range(0, BN - 1)] = 1'b0; len = $urandom_range(1, 3);
      end else begin
        v = '0; len = $urandom_range(50, 200);
      end
      repeat (len) b_cycle(v);
    end

    // Short periodic glitches keep requalifying: no release, timeout retry instead.
    retry0   = int'(retry_b);
    rel_seen = 0;
    for (int k = 0; k < 420; k++) begin
      if (k >= 10 && st_b == 3'd2) rel_seen = 1;
      b_cycle((k % 30 == 0) ? 3'b110 : 3'b111);
    end
    chk("b_glitch_no_release", rel_seen, 0);
    chk("b_glitch_retry_grew", (int'(retry_b) > retry0) ? 1 : 0, 1);

    rst_b = 1'b1;
    model_reset();
    #1 b_cmp();
    @(negedge clk);
    rst_b = 1'b0;
    prev = 0;
    for (int k = 0; k < 30000; k++) begin
      if (pll_b && prev == 0) rises.push_back(k);
      if (!pll_b && prev == 1) falls.push_back(k);
      prev = int'(pll_b);
      b_cycle('0);
    end
    chk("b_timeout_pulse_count", (rises.size() >= 3 && falls.size() >= 3) ? 1 : 0, 1);
    if (rises.size() >= 3 && falls.size() >= 3) begin
      chk("b_timeout_period1", rises[1] - rises[0], BPR + BTO);
      chk("b_timeout_period2", rises[2] - rises[1], BPR + BTO);
      chk("b_timeout_width", falls[1] - rises[1], BPR);
    end
    chk("b_retry_saturated", int'(retry_b), 255);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
